axil_cmd_master: RTL

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_pkg.sv | 29 ++
 rtl/axil_cmd_fifo.sv | 53 +++++
 rtl/axil_cmd_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master: FSM states,
// response status codes and the AES peripheral register map.
package axil_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_RSP
  } state_t;

  // rsp_status is {timeout, xRESP[1:0]}
  localparam logic [2:0] STAT_OKAY    = 3'b000;
  localparam logic [2:0] STAT_SLVERR  = 3'b010;
  localparam logic [2:0] STAT_DECERR  = 3'b011;
  localparam logic [2:0] STAT_TIMEOUT = 3'b100;

  localparam logic [31:0] AES_CTRL_OFS = 32'h0000_0034;
  localparam logic [31:0] AES_KEY_OFS  = 32'h0000_0020;
  localparam logic [31:0] AES_STAT_OFS = 32'h0000_0024;
  localparam logic [31:0] AES_DIN_OFS  = 32'h0000_0030;

  function automatic logic [2:0] xresp_status(input logic [1:0] resp);
    return {1'b0, resp};
  endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// Show-ahead command FIFO; pushes while full and pops while empty are dropped,
// so the producer only ever sees a plain valid/ready handshake.
module axil_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that executes queued single-beat read/write commands one at
// a time, in order, with a per-phase timeout and a valid/ready response port.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [2:0]          rsp_status,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int FW    = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t state;
  state_t state_n;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic [FW-1:0]     fifo_rdata;
  logic              f_we;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done;
  logic              w_done;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        status_q;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic timeout_hit;
  logic in_phase;
  logic cap_b;
  logic cap_r;
  logic cap_to;

  // cmd_ready is forced low while reset is held and rises straight after release
  assign cmd_ready = S_AXI_ARESETN && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  axil_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .push      (fifo_push),
    .push_data ({cmd_we, cmd_addr, cmd_wdata}),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty)
  );

  assign {f_we, f_addr, f_wdata} = fifo_rdata;

  // VALID/READY are decoded from registered state, so each drops the cycle after its handshake
  assign M_AXI_AWVALID = (state == ST_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WB);
  assign M_AXI_ARVALID = (state == ST_RA);
  assign M_AXI_RREADY  = (state == ST_RD);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;

  assign rsp_valid  = (state == ST_RSP);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

  assign in_phase    = (state == ST_WR) || (state == ST_WB) ||
                       (state == ST_RA) || (state == ST_RD);
  assign timeout_hit = in_phase && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= ST_IDLE;
    else                state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    cap_b    = 1'b0;
    cap_r    = 1'b0;
    cap_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = f_we ? ST_WR : ST_RA;
        end
      end
      ST_WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_n = ST_WB;
        end else if (timeout_hit) begin
          state_n = ST_RSP;
          cap_to  = 1'b1;
        end
      end
      ST_WB: begin
        if (b_hs) begin
          state_n = ST_RSP;
          cap_b   = 1'b1;
        end else if (timeout_hit) begin
          state_n = ST_RSP;
          cap_to  = 1'b1;
        end
      end
      ST_RA: begin
        if (ar_hs) begin
          state_n = ST_RD;
        end else if (timeout_hit) begin
          state_n = ST_RSP;
          cap_to  = 1'b1;
        end
      end
      ST_RD: begin
        if (r_hs) begin
          state_n = ST_RSP;
          cap_r   = 1'b1;
        end else if (timeout_hit) begin
          state_n = ST_RSP;
          cap_to  = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so each phase gets a full TIMEOUT budget
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      cnt      <= '0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      if (state_n != state)  cnt <= '0;
      else if (in_phase)     cnt <= cnt + CNT_W'(1);

      if (state == ST_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if (cap_b) begin
        rdata_q  <= '0;
        status_q <= xresp_status(M_AXI_BRESP);
      end else if (cap_r) begin
        rdata_q  <= M_AXI_RDATA;
        status_q <= xresp_status(M_AXI_RRESP);
      end else if (cap_to) begin
        rdata_q  <= '0;
        status_q <= STAT_TIMEOUT;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (fifo_pop) begin
      addr_q  <= f_addr;
      wdata_q <= f_wdata;
    end
  end

endmodule
